// File: rtl/tb_mem_sequencer.sv
// Program-run sequencer for the riscV bench: loads instruction memory, releases the core reset, arbitrates data memory and dumps a result region.
// Optional RUN-phase watchdog is compiled in when SEQ_WATCHDOG_EN is defined; otherwise RUN ends only on dut_halt and timeout stays 0.
module tb_mem_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] IMEM_BASE  = 32'h0000_0000,
  parameter int                IMEM_WORDS = 1024,
  parameter int                RST_CYCLES = 2,
  parameter int                RUN_CYCLES = 4096,
  parameter logic [ADDR_W-1:0] DUMP_BASE  = 32'h1001_0000,
  parameter int                DUMP_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ld_en,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_eof,
  output logic              imem_wr_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data,
  input  logic [ADDR_W-1:0] dut_pc,
  output logic              dut_rst,
  input  logic              dut_halt,
  input  logic              dut_dmem_rd,
  input  logic              dut_dmem_wr,
  input  logic [ADDR_W-1:0] dut_dmem_addr,
  input  logic [DATA_W-1:0] dut_dmem_wdata,
  output logic              dmem_rd_n,
  output logic              dmem_wr_n,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              sink_en,
  output logic [2:0]        phase,
  output logic              timeout,
  output logic              overflow,
  output logic              done
);

  localparam int LD_W = $clog2(IMEM_WORDS + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int DP_W = $clog2(DUMP_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RESET = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state, state_next;
  logic [LD_W-1:0]   ld_cnt, ld_cnt_next;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_next;
  logic [DP_W-1:0]   dump_cnt, dump_cnt_next;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_next;
  logic [DATA_W-1:0] imem_data_q, imem_data_next;
  logic              imem_wr_n_q, imem_wr_n_next;
  logic              sink_en_q, sink_en_next;
  logic              overflow_q, overflow_next;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(RUN_CYCLES + 1);
  logic [WD_W-1:0]   wd_cnt, wd_cnt_next;
  logic              timeout_q, timeout_next;
`endif

  always_comb begin
    state_next     = state;
    ld_cnt_next    = ld_cnt;
    rst_cnt_next   = rst_cnt;
    dump_cnt_next  = dump_cnt;
    imem_addr_next = imem_addr_q;
    imem_data_next = imem_data_q;
    imem_wr_n_next = 1'b1;
    overflow_next  = overflow_q;
    // The sink samples the read data one cycle after each dump read issues.
    sink_en_next   = (state == S_DUMP);
`ifdef SEQ_WATCHDOG_EN
    wd_cnt_next    = wd_cnt;
    timeout_next   = timeout_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next  = S_LOAD;
          ld_cnt_next = '0;
        end
      end
      S_LOAD: begin
        if (ld_eof) begin
          state_next   = S_RESET;
          rst_cnt_next = '0;
        end else if (ld_cnt == LD_W'(IMEM_WORDS)) begin
          overflow_next = 1'b1;
          state_next    = S_RESET;
          rst_cnt_next  = '0;
        end else begin
          imem_data_next = ld_data;
          imem_addr_next = IMEM_BASE + (ADDR_W'(ld_cnt) << 2);
          imem_wr_n_next = 1'b0;
          ld_cnt_next    = ld_cnt + LD_W'(1);
        end
      end
      S_RESET: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
          state_next = S_RUN;
`ifdef SEQ_WATCHDOG_EN
          wd_cnt_next = '0;
`endif
        end else begin
          rst_cnt_next = rst_cnt + RC_W'(1);
        end
      end
      S_RUN: begin
`ifdef SEQ_WATCHDOG_EN
        wd_cnt_next = wd_cnt + WD_W'(1);
        // Expiry wins over a simultaneous halt so the timeout is never lost.
        if (wd_cnt == WD_W'(RUN_CYCLES - 1)) begin
          timeout_next  = 1'b1;
          state_next    = S_DUMP;
          dump_cnt_next = '0;
        end else if (dut_halt) begin
          state_next    = S_DUMP;
          dump_cnt_next = '0;
        end
`else
        if (dut_halt) begin
          state_next    = S_DUMP;
          dump_cnt_next = '0;
        end
`endif
      end
      S_DUMP: begin
        if (dump_cnt == DP_W'(DUMP_WORDS - 1)) begin
          state_next = S_FLUSH;
        end else begin
          dump_cnt_next = dump_cnt + DP_W'(1);
        end
      end
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ld_cnt      <= '0;
      rst_cnt     <= '0;
      dump_cnt    <= '0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      imem_wr_n_q <= 1'b1;
      sink_en_q   <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      ld_cnt      <= ld_cnt_next;
      rst_cnt     <= rst_cnt_next;
      dump_cnt    <= dump_cnt_next;
      imem_addr_q <= imem_addr_next;
      imem_data_q <= imem_data_next;
      imem_wr_n_q <= imem_wr_n_next;
      sink_en_q   <= sink_en_next;
      overflow_q  <= overflow_next;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt      <= wd_cnt_next;
      timeout_q   <= timeout_next;
`endif
    end
  end

  // Data port ownership: the core in RUN, the sequencer in DUMP, idle otherwise.
  always_comb begin
    dmem_rd_n  = 1'b1;
    dmem_wr_n  = 1'b1;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      S_RUN: begin
        dmem_rd_n  = ~dut_dmem_rd;
        dmem_wr_n  = ~dut_dmem_wr;
        dmem_addr  = dut_dmem_addr;
        dmem_wdata = dut_dmem_wdata;
      end
      S_DUMP: begin
        dmem_rd_n = 1'b0;
        dmem_addr = DUMP_BASE + (ADDR_W'(dump_cnt) << 2);
      end
      default: ;
    endcase
  end

  assign imem_addr = (state == S_RUN) ? dut_pc : imem_addr_q;
  assign imem_wr_n = (state == S_RUN) ? 1'b1 : imem_wr_n_q;
  assign imem_data = imem_data_q;
  assign ld_en     = (state == S_LOAD);
  assign dut_rst   = (state != S_RUN);
  assign sink_en   = sink_en_q;
  assign phase     = state;
  assign overflow  = overflow_q;
  assign done      = (state == S_DONE);

`ifdef SEQ_WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tb_mem_sequencer.sv
// Scoreboard bench for tb_mem_sequencer: load, run pass-through, dump, watchdog, overflow and mid-dump reset.
// Watchdog expectations follow whether SEQ_WATCHDOG_EN is defined for the build.
module tb_tb_mem_sequencer;

  localparam int          IMEM_WORDS = 4;
  localparam int          RST_CYCLES = 2;
  localparam int          RUN_CYCLES = 16;
  localparam int          DUMP_WORDS = 256;
  localparam logic [31:0] DUMP_BASE  = 32'h1001_0000;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_LOAD  = 3'd1;
  localparam logic [2:0] P_RESET = 3'd2;
  localparam logic [2:0] P_RUN   = 3'd3;
  localparam logic [2:0] P_DUMP  = 3'd4;
  localparam logic [2:0] P_DONE  = 3'd6;

  logic        clk = 1'b0;
  logic        rst, start, ld_eof, dut_halt, dut_dmem_rd, dut_dmem_wr;
  logic [31:0] ld_data, dut_pc, dut_dmem_addr, dut_dmem_wdata;
  logic        ld_en, imem_wr_n, dut_rst, dmem_rd_n, dmem_wr_n, sink_en;
  logic        timeout, overflow, done;
  logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  logic [63:0] imem_q[$];
  logic [31:0] sink_q[$];
  logic [31:0] file_words[$];
  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] rdata;

  tb_mem_sequencer #(
    .IMEM_WORDS(IMEM_WORDS),
    .RST_CYCLES(RST_CYCLES),
    .RUN_CYCLES(RUN_CYCLES),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_WORDS(DUMP_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_en(ld_en), .ld_data(ld_data), .ld_eof(ld_eof),
    .imem_wr_n(imem_wr_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .dut_pc(dut_pc), .dut_rst(dut_rst), .dut_halt(dut_halt),
    .dut_dmem_rd(dut_dmem_rd), .dut_dmem_wr(dut_dmem_wr),
    .dut_dmem_addr(dut_dmem_addr), .dut_dmem_wdata(dut_dmem_wdata),
    .dmem_rd_n(dmem_rd_n), .dmem_wr_n(dmem_wr_n),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .sink_en(sink_en), .phase(phase), .timeout(timeout),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  // Data memory covering the dump region, one-cycle read latency.
  wire [31:0] dm_off = dmem_addr - DUMP_BASE;
  wire [7:0]  dm_idx = dm_off[9:2];
  wire        dm_hit = (dm_off < 32'd1024);

  always @(posedge clk) begin
    if (!dmem_wr_n && dm_hit) mem[dm_idx] <= dmem_wdata;
    if (!dmem_rd_n) rdata <= dm_hit ? mem[dm_idx] : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({phase, dut_rst, imem_wr_n, dmem_wr_n, dmem_rd_n, ld_en, sink_en, done, timeout, overflow}
        !== {P_IDLE, 4'b1111, 5'b00000})
      begin errors++; $display("[TB] FAIL reset_ctrl got %b want %b",
        {phase, dut_rst, imem_wr_n, dmem_wr_n, dmem_rd_n, ld_en, sink_en, done, timeout, overflow},
        {P_IDLE, 4'b1111, 5'b00000}); end
    checks++;
    if ({imem_addr, imem_data, dmem_addr, dmem_wdata} !== 128'h0)
      begin errors++; $display("[TB] FAIL reset_bus got %h want 0",
        {imem_addr, imem_data, dmem_addr, dmem_wdata}); end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({phase, dut_rst, ld_en} !== {P_IDLE, 1'b1, 1'b0})
      begin errors++; $display("[TB] FAIL idle_hold got %b want %b", {phase, dut_rst, ld_en},
        {P_IDLE, 1'b1, 1'b0}); end
  endtask

  task automatic test_load(input int nwords, input int exp_writes, input logic exp_ovf);
    int   i, guard, dut_writes, rc;
    logic pushed;
    logic [63:0] e;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({phase, ld_en} !== {P_LOAD, 1'b1})
      begin errors++; $display("[TB] FAIL load_entry got %b want %b", {phase, ld_en}, {P_LOAD, 1'b1}); end
    i = 0; guard = 0; dut_writes = 0;
    while (phase === P_LOAD && guard < 64) begin
      ld_eof  = (i >= nwords);
      ld_data = (i < nwords) ? file_words[i] : 32'h0;
      pushed  = 1'b0;
      if (!ld_eof && i < IMEM_WORDS) begin
        imem_q.push_back({32'(i * 4), file_words[i]});
        pushed = 1'b1;
      end
      tick();
      if (imem_wr_n === 1'b0) dut_writes++;
      checks++;
      if (imem_wr_n !== !pushed)
        begin errors++; $display("[TB] FAIL imem_wr_n word %0d got %b want %b", i, imem_wr_n, !pushed); end
      if (pushed) begin
        e = imem_q.pop_front();
        checks++;
        if ({imem_addr, imem_data} !== e)
          begin errors++; $display("[TB] FAIL imem_write word %0d got %h want %h", i,
            {imem_addr, imem_data}, e); end
      end
      i++;
      guard++;
    end
    ld_eof  = 1'b0;
    ld_data = 32'h0;
    checks++;
    if (guard >= 64 || phase !== P_RESET)
      begin errors++; $display("[TB] FAIL load_exit got phase %0d want %0d", phase, P_RESET); end
    checks++;
    if (overflow !== exp_ovf)
      begin errors++; $display("[TB] FAIL overflow got %b want %b", overflow, exp_ovf); end
    checks++;
    if (dut_writes != exp_writes)
      begin errors++; $display("[TB] FAIL write_count got %0d want %0d", dut_writes, exp_writes); end
    rc = 0;
    while (phase === P_RESET && rc < 20) begin
      checks++;
      if (dut_rst !== 1'b1)
        begin errors++; $display("[TB] FAIL reset_hold got %b want 1", dut_rst); end
      tick();
      rc++;
    end
    checks++;
    if (rc != RST_CYCLES || phase !== P_RUN || dut_rst !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_len got %0d/%0d/%b want %0d/%0d/0", rc, phase, dut_rst,
        RST_CYCLES, P_RUN); end
  endtask

  task automatic test_run_passthrough();
    dut_pc = 32'h8;
    #1;
    checks++;
    if ({imem_addr, imem_wr_n} !== {32'h8, 1'b1})
      begin errors++; $display("[TB] FAIL run_pc got %h want %h", {imem_addr, imem_wr_n}, {32'h8, 1'b1}); end
    dut_dmem_wr = 1'b1; dut_dmem_addr = 32'h1001_0008; dut_dmem_wdata = 32'hDEAD_BEEF;
    exp_mem[2] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({dmem_wr_n, dmem_rd_n, dmem_addr, dmem_wdata} !== {1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF})
      begin errors++; $display("[TB] FAIL run_write got %h want %h", {dmem_wr_n, dmem_rd_n, dmem_addr, dmem_wdata},
        {1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF}); end
    tick();
    dut_dmem_addr = 32'h1001_0010; dut_dmem_wdata = 32'h1234_5678; dut_pc = 32'hC;
    exp_mem[4] = 32'h1234_5678;
    #1;
    checks++;
    if ({imem_addr, dmem_wr_n, dmem_addr} !== {32'hC, 1'b0, 32'h1001_0010})
      begin errors++; $display("[TB] FAIL run_write2 got %h want %h", {imem_addr, dmem_wr_n, dmem_addr},
        {32'hC, 1'b0, 32'h1001_0010}); end
    tick();
    dut_dmem_wr = 1'b0; dut_dmem_rd = 1'b1; dut_dmem_addr = 32'h1001_0004;
    #1;
    checks++;
    if ({dmem_rd_n, dmem_wr_n, dmem_addr} !== {1'b0, 1'b1, 32'h1001_0004})
      begin errors++; $display("[TB] FAIL run_read got %h want %h", {dmem_rd_n, dmem_wr_n, dmem_addr},
        {1'b0, 1'b1, 32'h1001_0004}); end
    tick();
    dut_dmem_rd = 1'b0;
    dut_halt = 1'b1;
    tick();
    dut_halt = 1'b0;
    checks++;
    if ({phase, timeout, dut_rst} !== {P_DUMP, 1'b0, 1'b1})
      begin errors++; $display("[TB] FAIL halt_dump got %b want %b", {phase, timeout, dut_rst},
        {P_DUMP, 1'b0, 1'b1}); end
  endtask

  task automatic test_dump();
    int cyc, pulses, k;
    logic [31:0] got, exp, last_addr, third;
    cyc = 0; pulses = 0; k = 0; last_addr = 32'h0; third = 32'h0;
    while (phase !== P_DONE && cyc < 400) begin
      if (sink_en === 1'b1) begin
        got = rdata;
        exp = (sink_q.size() > 0) ? sink_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (got !== exp)
          begin errors++; $display("[TB] FAIL sink_data pulse %0d got %h want %h", pulses, got, exp); end
        if (pulses == 2) third = got;
        pulses++;
      end
      if (phase === P_DUMP) begin
        checks++;
        if ({dmem_rd_n, dmem_wr_n, dmem_addr} !== {1'b0, 1'b1, DUMP_BASE + 32'(k * 4)})
          begin errors++; $display("[TB] FAIL dump_addr word %0d got %h want %h", k,
            {dmem_rd_n, dmem_wr_n, dmem_addr}, {1'b0, 1'b1, DUMP_BASE + 32'(k * 4)}); end
        last_addr = dmem_addr;
        sink_q.push_back(exp_mem[k[7:0]]);
        k++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (pulses != DUMP_WORDS || sink_q.size() != 0)
      begin errors++; $display("[TB] FAIL sink_count got %0d want %0d", pulses, DUMP_WORDS); end
    checks++;
    if (k != DUMP_WORDS || last_addr !== 32'h1001_03FC)
      begin errors++; $display("[TB] FAIL dump_range got %0d/%h want %0d/100103fc", k, last_addr, DUMP_WORDS); end
    checks++;
    if (third !== 32'hDEAD_BEEF)
      begin errors++; $display("[TB] FAIL third_pulse got %h want deadbeef", third); end
    checks++;
    if ({phase, done, sink_en, dut_rst} !== {P_DONE, 1'b1, 1'b0, 1'b1})
      begin errors++; $display("[TB] FAIL done_state got %b want %b", {phase, done, sink_en, dut_rst},
        {P_DONE, 1'b1, 1'b0, 1'b1}); end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if ({phase, done} !== {P_DONE, 1'b1})
      begin errors++; $display("[TB] FAIL done_hold got %b want %b", {phase, done}, {P_DONE, 1'b1}); end
  endtask

  task automatic test_watchdog();
    int rc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({phase, done, timeout} !== {P_IDLE, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL rerun_reset got %b want %b", {phase, done, timeout},
        {P_IDLE, 1'b0, 1'b0}); end
    file_words = '{32'h0050_0093, 32'h0010_0113, 32'h0000_0073};
    test_load(3, 3, 1'b0);
`ifdef SEQ_WATCHDOG_EN
    rc = 0;
    while (phase === P_RUN && rc < 100) begin
      tick();
      rc++;
    end
    checks++;
    if (rc != RUN_CYCLES || phase !== P_DUMP || timeout !== 1'b1)
      begin errors++; $display("[TB] FAIL watchdog got %0d/%0d/%b want %0d/%0d/1", rc, phase, timeout,
        RUN_CYCLES, P_DUMP); end
`else
    rc = 0;
    repeat (40) begin
      tick();
      rc++;
    end
    checks++;
    if ({phase, timeout, dut_rst} !== {P_RUN, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL no_watchdog after %0d got %b want %b", rc, {phase, timeout, dut_rst},
        {P_RUN, 1'b0, 1'b0}); end
    dut_halt = 1'b1;
    tick();
    dut_halt = 1'b0;
    checks++;
    if (phase !== P_DUMP)
      begin errors++; $display("[TB] FAIL halt_only got %0d want %0d", phase, P_DUMP); end
`endif
  endtask

  task automatic test_rst_mid_dump();
    repeat (5) tick();
    checks++;
    if ({phase, sink_en} !== {P_DUMP, 1'b1})
      begin errors++; $display("[TB] FAIL mid_dump got %b want %b", {phase, sink_en}, {P_DUMP, 1'b1}); end
    rst = 1'b1;
    tick();
    checks++;
    if ({phase, sink_en, done, dut_rst, dmem_rd_n, imem_wr_n, timeout, overflow}
        !== {P_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL dump_abort got %b want %b",
        {phase, sink_en, done, dut_rst, dmem_rd_n, imem_wr_n, timeout, overflow},
        {P_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}); end
    rst = 1'b0;
    tick();
    checks++;
    if (phase !== P_IDLE)
      begin errors++; $display("[TB] FAIL abort_idle got %0d want %0d", phase, P_IDLE); end
  endtask

  task automatic test_overflow();
    file_words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                   32'h4444_0004, 32'h5555_0005, 32'h6666_0006};
    test_load(6, IMEM_WORDS, 1'b1);
    checks++;
    if ({overflow, phase} !== {1'b1, P_RUN})
      begin errors++; $display("[TB] FAIL overflow_run got %b want %b", {overflow, phase}, {1'b1, P_RUN}); end
  endtask

  task automatic test_halt_and_watchdog();
    logic exp_to;
`ifdef SEQ_WATCHDOG_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    repeat (RUN_CYCLES - 1) tick();
    dut_halt = 1'b1;
    tick();
    dut_halt = 1'b0;
    checks++;
    if ({phase, timeout} !== {P_DUMP, exp_to})
      begin errors++; $display("[TB] FAIL halt_and_wd got %b want %b", {phase, timeout}, {P_DUMP, exp_to}); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout phase %0d", phase);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ld_eof = 1'b0; ld_data = 32'h0;
    dut_pc = 32'h0; dut_halt = 1'b0; dut_dmem_rd = 1'b0; dut_dmem_wr = 1'b0;
    dut_dmem_addr = 32'h0; dut_dmem_wdata = 32'h0;
    for (int j = 0; j < 256; j++) begin
      mem[j]     = 32'h0;
      exp_mem[j] = 32'h0;
    end
    test_reset();
    file_words = '{32'h0050_0093, 32'h0010_0113, 32'h0000_0073};
    test_load(3, 3, 1'b0);
    test_run_passthrough();
    test_dump();
    test_watchdog();
    test_rst_mid_dump();
    test_overflow();
    test_halt_and_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
